// File: rtl/fpga_link_pkg.sv
// -----------------------------------------------------------------------------
// fpga_link_pkg
// Shared definitions for the inter-FPGA word link (sender and receiver sides).
//   WORD_W              : width of one transferred word
//   DEF_RECEIVE_COUNT   : default number of words per transfer
//   DEF_CAPTURE_DELAY   : default cycles from rdy rising to the first valid word
//   DEF_ACK_TIMEOUT     : default cycles ack may wait for req to fall
//   link_state_e        : receiver FSM state encodings
//   addr_w()            : address width needed to index a buffer of given depth
// -----------------------------------------------------------------------------
package fpga_link_pkg;

    localparam int WORD_W            = 32;
    localparam int DEF_RECEIVE_COUNT = 10;
    localparam int DEF_CAPTURE_DELAY = 2;
    localparam int DEF_ACK_TIMEOUT   = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_ACK     = 3'd3,
        ST_DRAIN   = 3'd4
    } link_state_e;

    // A single-entry buffer still needs a one-bit address port.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/link_rx_buffer.sv
// -----------------------------------------------------------------------------
// link_rx_buffer
// DEPTH x DATA_W word store for one received transfer.
//   clk      : clock
//   wr_en    : write wr_data at wr_addr this edge
//   wr_addr  : write address
//   wr_data  : write word
//   rd_en    : load the read register from rd_addr this edge
//   rd_addr  : read address
//   rd_data  : registered read word; holds its value while rd_en is low
// Storage and the read register carry no reset: their contents are only
// observed after the receiver has written and addressed them.
// -----------------------------------------------------------------------------
module link_rx_buffer
    import fpga_link_pkg::*;
#(
    parameter int DEPTH  = DEF_RECEIVE_COUNT,
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_p1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // ---- read stage: address in, word out one cycle later ----
        if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_p1;

endmodule

// File: rtl/fpga2_receiver.sv
// -----------------------------------------------------------------------------
// fpga2_receiver
// Receives a fixed-length burst of words from a sender FPGA, acknowledges it,
// then streams the words to a downstream consumer with valid/ready flow control.
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   req_in    in   request from the sender
//   data_in   in   word bus from the sender
//   rdy_out   out  ready to the sender (registered)
//   ack_out   out  transfer acknowledge to the sender (registered)
//   data_out  out  word to downstream, zero whenever valid_out is low
//   valid_out out  data_out valid
//   ready_in  in   downstream accepts on valid_out && ready_in
//   done      out  one-cycle pulse after the last word is accepted
// Parameters: RECEIVE_COUNT (1..1023 words), CAPTURE_DELAY (>= 1 cycles),
// ACK_TIMEOUT (>= 1 cycles).
// -----------------------------------------------------------------------------
module fpga2_receiver
    import fpga_link_pkg::*;
#(
    parameter int RECEIVE_COUNT = DEF_RECEIVE_COUNT,
    parameter int CAPTURE_DELAY = DEF_CAPTURE_DELAY,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [WORD_W-1:0] data_in,
    output logic              rdy_out,
    output logic              ack_out,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              done
);

    localparam int IDX_W  = $clog2(RECEIVE_COUNT + 1);
    localparam int BUF_AW = addr_w(RECEIVE_COUNT);
    localparam int DLY_W  = $clog2(CAPTURE_DELAY + 1);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RECEIVE_COUNT - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CAPTURE_DELAY - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    link_state_e       state_q, state_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  rd_nxt;
    logic              rdy_q, rdy_d;
    logic              ack_q, ack_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;

    logic              wr_en;
    logic              rd_en;
    logic [BUF_AW-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;

    link_rx_buffer #(
        .DEPTH  (RECEIVE_COUNT),
        .DATA_W (WORD_W),
        .ADDR_W (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_idx_q[BUF_AW-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state and registered-output decode. Outputs are computed for the
    // state being entered so that rdy/ack/valid/done come straight from flops.
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        ack_cnt_d = ack_cnt_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        rd_nxt    = rd_idx_q + 1'b1;
        rdy_d     = 1'b0;
        ack_d     = 1'b0;
        vld_d     = 1'b0;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = rd_idx_q[BUF_AW-1:0];

        case (state_q)
            ST_IDLE: begin
                dly_cnt_d = '0;
                ack_cnt_d = '0;
                wr_idx_d  = '0;
                rd_idx_d  = '0;
                if (req_in) begin
                    state_d = ST_ARM;
                    rdy_d   = 1'b1;
                end
            end

            ST_ARM: begin
                if (!req_in) begin
                    state_d = ST_IDLE;
                end else begin
                    rdy_d = 1'b1;
                    if (dly_cnt_q == DLY_LAST) begin
                        state_d   = ST_CAPTURE;
                        dly_cnt_d = '0;
                        wr_idx_d  = '0;
                    end else begin
                        dly_cnt_d = dly_cnt_q + 1'b1;
                    end
                end
            end

            ST_CAPTURE: begin
                // A falling request always aborts; a partial burst is never acked.
                if (!req_in) begin
                    state_d = ST_IDLE;
                end else begin
                    rdy_d    = 1'b1;
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == IDX_LAST) begin
                        state_d   = ST_ACK;
                        ack_d     = 1'b1;
                        ack_cnt_d = '0;
                    end
                end
            end

            ST_ACK: begin
                if (!req_in) begin
                    // Prefetch word 0 so it is on data_out in the first drain cycle.
                    state_d  = ST_DRAIN;
                    vld_d    = 1'b1;
                    rd_idx_d = '0;
                    rd_en    = 1'b1;
                    rd_addr  = '0;
                end else if (ack_cnt_q == ACK_LAST) begin
                    // Sender never saw the ack: drop rdy/ack for a cycle and
                    // discard the burst so it is resent from scratch.
                    state_d = ST_IDLE;
                end else begin
                    ack_d     = 1'b1;
                    rdy_d     = 1'b1;
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                // req_in is ignored here; rdy stays low until back in IDLE.
                vld_d = 1'b1;
                if (vld_q && ready_in) begin
                    if (rd_idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rd_idx_d = rd_nxt;
                        rd_en    = 1'b1;
                        rd_addr  = rd_nxt[BUF_AW-1:0];
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                dly_cnt_d = '0;
                ack_cnt_d = '0;
                wr_idx_d  = '0;
                rd_idx_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dly_cnt_q <= '0;
            ack_cnt_q <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            rdy_q     <= 1'b0;
            ack_q     <= 1'b0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            rdy_q     <= rdy_d;
            ack_q     <= ack_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
        end
    end

    assign rdy_out   = rdy_q;
    assign ack_out   = ack_q;
    assign valid_out = vld_q;
    assign done      = done_q;
    // The read register has no reset; gating keeps data_out at zero when idle.
    assign data_out  = vld_q ? rd_data : '0;

endmodule

// File: doc/fpga2_receiver.md
FPGA2_RECEIVER -- requirements
Module: fpga2_receiver

Interface
REQ-001 SHALL have parameter RECEIVE_COUNT, default 10, meaning the number of 32-bit words per transfer (range 1..1023).
REQ-002 SHALL have parameter CAPTURE_DELAY, default 2, meaning the cycles from the first cycle rdy_out is high to the first valid word on data_in.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, meaning the cycles ack_out may stay high waiting for req_in to fall.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_in  in  1  request from the sender FPGA.
REQ-007 data_in  in  32  word bus from the sender FPGA.
REQ-008 rdy_out  out  1  ready to the sender FPGA.
REQ-009 ack_out  out  1  transfer acknowledge to the sender FPGA.
REQ-010 data_out  out  32  word to the downstream process.
REQ-011 valid_out  out  1  data_out valid.
REQ-012 ready_in  in  1  downstream accepts the word when valid_out && ready_in.
REQ-013 done  out  1  one-cycle pulse when the last word of a transfer is accepted downstream.

Function
REQ-014 States SHALL be IDLE, ARM, CAPTURE, ACK, DRAIN; encoding constants in the package.
REQ-015 IDLE: all outputs low; on req_in=1 -> ARM.
REQ-016 ARM: rdy_out=1 (registered); delay counter counts CAPTURE_DELAY cycles, then -> CAPTURE.
REQ-017 CAPTURE: rdy_out=1; one data_in word per cycle written to buffer[wr_idx], wr_idx incrementing from 0; after RECEIVE_COUNT words -> ACK.
REQ-018 Buffer SHALL be RECEIVE_COUNT x 32; index/counter width $clog2(RECEIVE_COUNT+1); no wrap within a transfer.
REQ-019 ACK: ack_out=1, rdy_out held 1; when req_in falls -> DRAIN with ack_out=0 and rdy_out=0 the next cycle.
REQ-020 ACK timeout: if req_in stays high ACK_TIMEOUT cycles, drop ack_out and rdy_out for one cycle, discard the buffer, -> IDLE (sender sees !rdy and resends).
REQ-021 Abort: req_in low in ARM or CAPTURE -> discard partial words, rdy_out=0, -> IDLE next cycle; no done, no ack.
REQ-022 DRAIN: words presented in index order, valid_out=1; rd_idx advances only on valid_out && ready_in; data_out stable while valid_out && !ready_in.
REQ-023 After the handshake on word RECEIVE_COUNT-1: done=1 for exactly that next cycle, valid_out=0, -> IDLE.
REQ-024 rdy_out SHALL never be 1 in DRAIN; a new req_in during DRAIN waits until IDLE (backpressure to sender).
REQ-025 Simultaneous req_in fall and ack_out rise SHALL be unreachable; req_in=0 on the ACK entry cycle is accepted as completion (-> DRAIN).
REQ-026 Illegal state encoding -> IDLE next cycle, buffer discarded.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE; rdy_out, ack_out, valid_out, done=0; data_out=0; all counters/indices=0; buffer contents don't-care.
REQ-028 rst mid-transfer (any state) SHALL take effect that edge; no done or ack follows.

Structure
REQ-029 Package fpga_link_pkg SHALL hold state encodings, word width (32), and default RECEIVE_COUNT/CAPTURE_DELAY shared with the sender.
REQ-030 One sub-module, link_rx_buffer (RECEIVE_COUNT x 32 storage with write port and registered read port), is natural; the FSM and counters stay in fpga2_receiver.

Verification
REQ-031 Nominal: req_in rises, data_in=0x100+i from 2 cycles after rdy_out rises, ready_in=1 -> ack_out high after 10 words; req_in drop -> data_out 0x100..0x109 in order, done pulse once.
REQ-032 Backpressure: ready_in toggles 1/0 every cycle in DRAIN -> each word held until accepted, no loss/duplication, done after 10th handshake; req_in during DRAIN sees rdy_out=0.
REQ-033 Abort: req_in falls after 4 captured words -> rdy_out=0 next cycle, no ack/done; following full transfer delivers only new words.
REQ-034 Timeout: req_in held high 15 cycles after ack_out -> rdy_out/ack_out low one cycle, IDLE; resent transfer with 0x200+i delivered correctly.
REQ-035 Reset mid-CAPTURE after 5 words -> all outputs 0 next cycle, state IDLE, no done.
REQ-036 RECEIVE_COUNT=1 build: single word 0xDEADBEEF -> ack, drain, done.
